// File: rtl/mpc_wbuffer_pkg.sv
// Shared types and default sizing for the MPC write buffer.
package mpc_wbuffer_pkg;

  localparam int unsigned MPC_NUM_ENTRY  = 8;
  localparam int unsigned MPC_DATA_WIDTH = 128;
  localparam int unsigned MPC_ID_WIDTH   = 8;
  localparam int unsigned MPC_CH_WIDTH   = 2;

  typedef logic [MPC_CH_WIDTH-1:0] mpc_chan_t;
  typedef logic [MPC_ID_WIDTH-1:0] mpc_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RTN  = 1'b1
  } mpc_rtn_state_e;

endpackage

// File: rtl/mpc_wbuffer_if.sv
// Fill, request/return and status signals of the MPC write buffer.
interface mpc_wbuffer_if
  import mpc_wbuffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MPC_DATA_WIDTH
) ();

  logic                  mpc_xbar_wbuf_valid;
  logic                  mpc_xbar_wbuf_enable;
  mpc_chan_t             mpc_xbar_wbuf_channel_id;
  logic [DATA_WIDTH-1:0] mpc_xbar_wbuf_data;
  mpc_id_t               mpc_xbar_wbuf_id;

  logic                  mpc_rc_wbuf_req_valid;
  logic                  mpc_rc_wbuf_req_enable;
  mpc_chan_t             mpc_rc_wbuf_req_channel_id;
  mpc_id_t               mpc_rc_wbuf_req_wbuffer_id;

  logic                  mpc_rc_wbuf_rtn_valid;
  logic                  mpc_rc_wbuf_rtn_enable;
  logic [DATA_WIDTH-1:0] mpc_rc_wbuf_rtn_data;

  logic                  mpc_wbuf_full;
  logic                  mpc_wbuf_empty;
  logic                  mpc_wbuf_err;

  // Buffer side
  modport slave (
    input  mpc_xbar_wbuf_valid, mpc_xbar_wbuf_channel_id, mpc_xbar_wbuf_data,
    output mpc_xbar_wbuf_enable, mpc_xbar_wbuf_id,
    input  mpc_rc_wbuf_req_valid, mpc_rc_wbuf_req_channel_id, mpc_rc_wbuf_req_wbuffer_id,
    output mpc_rc_wbuf_req_enable,
    output mpc_rc_wbuf_rtn_valid, mpc_rc_wbuf_rtn_data,
    input  mpc_rc_wbuf_rtn_enable,
    output mpc_wbuf_full, mpc_wbuf_empty, mpc_wbuf_err
  );

  // Crossbar / SRAM-controller side
  modport master (
    output mpc_xbar_wbuf_valid, mpc_xbar_wbuf_channel_id, mpc_xbar_wbuf_data,
    input  mpc_xbar_wbuf_enable, mpc_xbar_wbuf_id,
    output mpc_rc_wbuf_req_valid, mpc_rc_wbuf_req_channel_id, mpc_rc_wbuf_req_wbuffer_id,
    input  mpc_rc_wbuf_req_enable,
    input  mpc_rc_wbuf_rtn_valid, mpc_rc_wbuf_rtn_data,
    output mpc_rc_wbuf_rtn_enable,
    input  mpc_wbuf_full, mpc_wbuf_empty, mpc_wbuf_err
  );

endinterface

// File: rtl/mpc_wbuf_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module mpc_wbuf_prio_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    o_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_found = |i_vec;

endmodule

// File: rtl/mpc_wbuffer.sv
// Write buffer: allocates lowest free entry on fill, returns entry data to the
// SRAM controller through a one-deep IDLE/RTN return FSM and frees it on completion.
module mpc_wbuffer
  import mpc_wbuffer_pkg::*;
#(
  parameter int unsigned NUM_ENTRY  = MPC_NUM_ENTRY,
  parameter int unsigned DATA_WIDTH = MPC_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mpc_wbuffer_if.slave  bus
);

  localparam int unsigned IDX_W    = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
  localparam int unsigned ID_EXT_W = MPC_ID_WIDTH + 1;

  logic [NUM_ENTRY-1:0]  r_valid;
  logic [NUM_ENTRY-1:0]  w_valid_nxt;
  logic [NUM_ENTRY-1:0]  w_free_vec;
  mpc_chan_t             r_chan [NUM_ENTRY];
  logic [DATA_WIDTH-1:0] r_data [NUM_ENTRY];

  logic [IDX_W-1:0]      w_free_idx;
  logic                  w_free_found;

  mpc_rtn_state_e        r_state;
  mpc_rtn_state_e        w_state_nxt;
  logic [IDX_W-1:0]      r_rtn_idx;
  logic                  r_rtn_legal;
  logic [DATA_WIDTH-1:0] r_rtn_data;
  logic                  r_err;
  logic                  r_full;
  logic                  r_empty;

  logic                  w_fill;
  logic                  w_req;
  logic                  w_rtn_done;
  logic                  w_release;
  logic                  w_req_in_range;
  logic                  w_req_legal;
  logic [IDX_W-1:0]      w_req_idx;

  assign w_free_vec = ~r_valid;

  mpc_wbuf_prio_enc #(
    .N     (NUM_ENTRY),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_vec   (w_free_vec),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  assign bus.mpc_xbar_wbuf_enable   = !r_full;
  assign bus.mpc_xbar_wbuf_id       = MPC_ID_WIDTH'(w_free_idx);
  assign bus.mpc_rc_wbuf_req_enable = (r_state == ST_IDLE);
  assign bus.mpc_rc_wbuf_rtn_valid  = (r_state == ST_RTN);
  assign bus.mpc_rc_wbuf_rtn_data   = r_rtn_data;
  assign bus.mpc_wbuf_full          = r_full;
  assign bus.mpc_wbuf_empty         = r_empty;
  assign bus.mpc_wbuf_err           = r_err;

  assign w_fill = bus.mpc_xbar_wbuf_valid && bus.mpc_xbar_wbuf_enable && w_free_found;
  assign w_req  = bus.mpc_rc_wbuf_req_valid && (r_state == ST_IDLE);

  // An entry being filled this cycle is not yet valid, so a request to it is illegal.
  assign w_req_idx      = bus.mpc_rc_wbuf_req_wbuffer_id[IDX_W-1:0];
  assign w_req_in_range = {1'b0, bus.mpc_rc_wbuf_req_wbuffer_id} < ID_EXT_W'(NUM_ENTRY);
  assign w_req_legal    = w_req_in_range && r_valid[w_req_idx] &&
                          (r_chan[w_req_idx] == bus.mpc_rc_wbuf_req_channel_id);

  // Return FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_rtn_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mpc_rc_wbuf_req_valid) w_state_nxt = ST_RTN;
      end
      ST_RTN: begin
        if (bus.mpc_rc_wbuf_rtn_enable) begin
          w_state_nxt = ST_IDLE;
          w_rtn_done  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_release = w_rtn_done && r_rtn_legal;

  // Fill picks a currently-free entry and release clears a valid one, so they never collide.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_fill)    w_valid_nxt[w_free_idx] = 1'b1;
    if (w_release) w_valid_nxt[r_rtn_idx]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_valid     <= '0;
      r_rtn_idx   <= '0;
      r_rtn_legal <= 1'b0;
      r_rtn_data  <= '0;
      r_err       <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_full  <= &w_valid_nxt;
      r_empty <= ~|w_valid_nxt;
      if (w_req) begin
        r_rtn_idx   <= w_req_idx;
        r_rtn_legal <= w_req_legal;
        r_rtn_data  <= w_req_legal ? r_data[w_req_idx] : '0;
        if (!w_req_legal) r_err <= 1'b1;
      end
    end
  end

  // Entry payload storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_free_idx] <= bus.mpc_xbar_wbuf_data;
      r_chan[w_free_idx] <= bus.mpc_xbar_wbuf_channel_id;
    end
  end

endmodule

// File: tb/tb_mpc_wbuffer.sv
// Directed plus randomized bench for mpc_wbuffer against an array-based model.
module tb_mpc_wbuffer;

  localparam int NE = 8;
  localparam int DW = 128;

  logic clk;
  logic rst;

  mpc_wbuffer_if #(.DATA_WIDTH(DW)) bus ();

  mpc_wbuffer #(.NUM_ENTRY(NE), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: entry table plus sticky error
  bit          m_valid [NE];
  logic [1:0]  m_chan  [NE];
  logic [DW-1:0] m_data [NE];
  bit          m_err;

  function automatic int m_lowest();
    for (int i = 0; i < NE; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NE; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    int lo;
    lo = m_lowest();
    chk({tag, ".full"},  DW'(bus.mpc_wbuf_full),  DW'(m_count() == NE));
    chk({tag, ".empty"}, DW'(bus.mpc_wbuf_empty), DW'(m_count() == 0));
    chk({tag, ".xen"},   DW'(bus.mpc_xbar_wbuf_enable), DW'(m_count() != NE));
    chk({tag, ".err"},   DW'(bus.mpc_wbuf_err),   DW'(m_err));
    if (lo >= 0) chk({tag, ".id"}, DW'(bus.mpc_xbar_wbuf_id), DW'(lo));
  endtask

  task automatic do_fill(input logic [1:0] ch, input logic [DW-1:0] d, output int id);
    int exp;
    exp = m_lowest();
    bus.mpc_xbar_wbuf_valid      = 1'b1;
    bus.mpc_xbar_wbuf_channel_id = ch;
    bus.mpc_xbar_wbuf_data       = d;
    for (int k = 0; k < 20 && !bus.mpc_xbar_wbuf_enable; k++) cyc();
    chk("fill_accept", DW'(bus.mpc_xbar_wbuf_enable), DW'(1));
    chk("fill_id", DW'(bus.mpc_xbar_wbuf_id), DW'(exp));
    id = int'(bus.mpc_xbar_wbuf_id);
    cyc();
    bus.mpc_xbar_wbuf_valid = 1'b0;
    if (exp >= 0) begin
      m_valid[exp] = 1'b1;
      m_chan[exp]  = ch;
      m_data[exp]  = d;
    end
    chk("fill_empty", DW'(bus.mpc_wbuf_empty), DW'(0));
  endtask

  task automatic do_req(input logic [1:0] ch, input logic [7:0] id, input int hold);
    bit legal;
    logic [DW-1:0] ed;
    legal = (id < NE) && m_valid[id[2:0]] && (m_chan[id[2:0]] == ch);
    ed    = legal ? m_data[id[2:0]] : '0;
    chk("req_enable_idle", DW'(bus.mpc_rc_wbuf_req_enable), DW'(1));
    bus.mpc_rc_wbuf_req_valid      = 1'b1;
    bus.mpc_rc_wbuf_req_channel_id = ch;
    bus.mpc_rc_wbuf_req_wbuffer_id = id;
    bus.mpc_rc_wbuf_rtn_enable     = 1'b0;
    cyc();
    bus.mpc_rc_wbuf_req_valid = 1'b0;
    if (!legal) m_err = 1'b1;
    chk("rtn_valid_rise", DW'(bus.mpc_rc_wbuf_rtn_valid), DW'(1));
    chk("rtn_data", bus.mpc_rc_wbuf_rtn_data, ed);
    chk("req_enable_busy", DW'(bus.mpc_rc_wbuf_req_enable), DW'(0));
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("rtn_valid_hold", DW'(bus.mpc_rc_wbuf_rtn_valid), DW'(1));
      chk("rtn_data_hold", bus.mpc_rc_wbuf_rtn_data, ed);
    end
    bus.mpc_rc_wbuf_rtn_enable = 1'b1;
    cyc();
    bus.mpc_rc_wbuf_rtn_enable = 1'b0;
    if (legal) m_valid[id[2:0]] = 1'b0;
    chk("rtn_valid_drop", DW'(bus.mpc_rc_wbuf_rtn_valid), DW'(0));
    chk_status("after_rtn");
  endtask

  // Buffer full: a fill waits while entry rid is returned, then takes rid.
  task automatic fill_vs_return(input int rid, input int hold);
    logic [DW-1:0] d;
    logic [1:0] ch;
    d  = rnd_data();
    ch = 2'($urandom);
    bus.mpc_xbar_wbuf_valid      = 1'b1;
    bus.mpc_xbar_wbuf_channel_id = ch;
    bus.mpc_xbar_wbuf_data       = d;
    chk("stall_full", DW'(bus.mpc_wbuf_full), DW'(1));
    chk("stall_xen", DW'(bus.mpc_xbar_wbuf_enable), DW'(0));
    bus.mpc_rc_wbuf_req_valid      = 1'b1;
    bus.mpc_rc_wbuf_req_channel_id = m_chan[rid];
    bus.mpc_rc_wbuf_req_wbuffer_id = 8'(rid);
    cyc();
    bus.mpc_rc_wbuf_req_valid = 1'b0;
    chk("fvr_rtn_data", bus.mpc_rc_wbuf_rtn_data, m_data[rid]);
    for (int h = 0; h < hold; h++) begin
      chk("fvr_stall_xen", DW'(bus.mpc_xbar_wbuf_enable), DW'(0));
      cyc();
    end
    bus.mpc_rc_wbuf_rtn_enable = 1'b1;
    chk("fvr_no_alloc", DW'(bus.mpc_xbar_wbuf_enable), DW'(0));
    cyc();
    bus.mpc_rc_wbuf_rtn_enable = 1'b0;
    m_valid[rid] = 1'b0;
    chk("fvr_freed_full", DW'(bus.mpc_wbuf_full), DW'(0));
    chk("fvr_xen", DW'(bus.mpc_xbar_wbuf_enable), DW'(1));
    chk("fvr_id", DW'(bus.mpc_xbar_wbuf_id), DW'(rid));
    cyc();
    bus.mpc_xbar_wbuf_valid = 1'b0;
    m_valid[rid] = 1'b1;
    m_chan[rid]  = ch;
    m_data[rid]  = d;
    chk_status("fvr_refilled");
  endtask

  initial begin
    int id;
    logic [DW-1:0] dB;

    rst = 1'b1;
    bus.mpc_xbar_wbuf_valid        = 1'b0;
    bus.mpc_xbar_wbuf_channel_id   = '0;
    bus.mpc_xbar_wbuf_data         = '0;
    bus.mpc_rc_wbuf_req_valid      = 1'b0;
    bus.mpc_rc_wbuf_req_channel_id = '0;
    bus.mpc_rc_wbuf_req_wbuffer_id = '0;
    bus.mpc_rc_wbuf_rtn_enable     = 1'b0;
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    m_err = 1'b0;
    repeat (3) cyc();

    // Reset values
    chk("rst_rtn_valid", DW'(bus.mpc_rc_wbuf_rtn_valid), DW'(0));
    chk("rst_err",       DW'(bus.mpc_wbuf_err), DW'(0));
    chk("rst_full",      DW'(bus.mpc_wbuf_full), DW'(0));
    chk("rst_empty",     DW'(bus.mpc_wbuf_empty), DW'(1));
    chk("rst_req_en",    DW'(bus.mpc_rc_wbuf_req_enable), DW'(1));
    chk("rst_xen",       DW'(bus.mpc_xbar_wbuf_enable), DW'(1));
    chk("rst_xid",       DW'(bus.mpc_xbar_wbuf_id), DW'(0));
    chk("rst_rtn_data",  bus.mpc_rc_wbuf_rtn_data, DW'(0));
    rst = 1'b0;
    cyc();

    // Test 1: three fills on channel 1
    do_fill(2'd1, rnd_data(), id); chk("t1_id0", DW'(id), DW'(0));
    dB = rnd_data();
    do_fill(2'd1, dB, id);         chk("t1_id1", DW'(id), DW'(1));
    do_fill(2'd1, rnd_data(), id); chk("t1_id2", DW'(id), DW'(2));
    chk_status("t1");

    // Test 2: return of entry 1 held for 4 cycles, then refill lands in 1
    do_req(2'd1, 8'd1, 4);
    chk("t2_data_model", m_data[1], dB);
    do_fill(2'($urandom), rnd_data(), id); chk("t2_refill_id", DW'(id), DW'(1));

    // Test 3: fill to full, ninth fill stalls across a slow return of entry 2
    while (m_count() < NE) do_fill(2'($urandom), rnd_data(), id);
    chk("t3_full", DW'(bus.mpc_wbuf_full), DW'(1));
    chk("t3_xen",  DW'(bus.mpc_xbar_wbuf_enable), DW'(0));
    fill_vs_return(2, 2);

    // Test 4: return of entry 5 completes in the first return cycle
    fill_vs_return(5, 0);

    // Test 5: out-of-range and wrong-channel requests
    do_req(2'($urandom), 8'd9, 1);
    chk("t5_err", DW'(bus.mpc_wbuf_err), DW'(1));
    do_req(m_chan[3] ^ 2'd1, 8'd3, 0);
    chk("t5_full_kept", DW'(bus.mpc_wbuf_full), DW'(1));

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      if (sel == 0 && m_count() < NE) begin
        do_fill(2'($urandom), rnd_data(), id);
      end else if (sel == 1 && m_count() > 0) begin
        int e;
        e = int'($urandom_range(0, NE - 1));
        while (!m_valid[e]) e = (e + 1) % NE;
        do_req(m_chan[e], 8'(e), int'($urandom_range(0, 2)));
      end else begin
        do_req(2'($urandom), 8'($urandom_range(0, 15)), 0);
      end
    end

    // Test 6: reset during a return
    if (m_count() == 0) do_fill(2'd2, rnd_data(), id);
    begin
      int e;
      e = 0;
      while (!m_valid[e]) e++;
      bus.mpc_rc_wbuf_req_valid      = 1'b1;
      bus.mpc_rc_wbuf_req_channel_id = m_chan[e];
      bus.mpc_rc_wbuf_req_wbuffer_id = 8'(e);
      cyc();
      bus.mpc_rc_wbuf_req_valid = 1'b0;
      chk("t6_in_rtn", DW'(bus.mpc_rc_wbuf_rtn_valid), DW'(1));
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
      m_err = 1'b0;
      chk("t6_rtn_valid", DW'(bus.mpc_rc_wbuf_rtn_valid), DW'(0));
      chk("t6_req_en",    DW'(bus.mpc_rc_wbuf_req_enable), DW'(1));
      chk_status("t6");
    end
    do_fill(2'd0, rnd_data(), id); chk("t6_post_id", DW'(id), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
